relu_maxpool: RTL and testbench

Downstream stage of the CNN convolution engine. After the engine's done pulse, this block takes the engine's feature map as a row-major valid/ready stream. It applies ReLU, then 2×2 stride-2 max pooling, and emits the pooled map on a second valid/ready stream. It then pulses `done`.

---
 rtl/cnn_pkg.sv | 10 +
 rtl/pool_line_buf.sv | 21 ++
 rtl/relu_maxpool.sv | 139 +++++++++++++
 tb/tb_relu_maxpool.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN post-processing stages.
package cnn_pkg;
  localparam int CNN_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic logic signed [CNN_DATA_W-1:0] relu(input logic signed [CNN_DATA_W-1:0] x);
    return x[CNN_DATA_W-1] ? '0 : x;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for 2x2 pooling: synchronous write, asynchronous read.
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a row-major valid/ready stream,
// emitting the pooled map on a second valid/ready stream and pulsing done.
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_W   = CNN_DATA_W,
  parameter int MAX_COLS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        rows,
  input  logic [6:0]        cols,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = MAX_COLS / 2;
  localparam int AW    = $clog2(DEPTH);

  state_t state_q, state_d;
  logic [6:0] rows_q, rows_d, cols_q, cols_d;
  logic [6:0] r_q, r_d, c_q, c_d;
  logic signed [DATA_W-1:0] hold_q, hold_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;

  logic signed [DATA_W-1:0] x_relu, pair_max, pool_max, buf_rdata;
  logic in_fire, out_fire, last_col, last_in, buf_we, new_res;
  logic [AW-1:0] buf_addr;

  // Single output register: input stalls only while it is full and not draining.
  assign in_ready = (state_q == RUN) && !(out_valid_q && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign x_relu   = relu($signed(in_data));
  assign pair_max = (x_relu > hold_q) ? x_relu : hold_q;
  assign pool_max = (pair_max > buf_rdata) ? pair_max : buf_rdata;

  assign last_col = (c_q == cols_q - 7'd1);
  assign last_in  = last_col && (r_q == rows_q - 7'd1);
  assign buf_addr = c_q[AW:1];
  assign buf_we   = in_fire && c_q[0] && !r_q[0];
  assign new_res  = in_fire && c_q[0] && r_q[0];

  pool_line_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(buf_addr),
    .wdata(pair_max),
    .raddr(buf_addr),
    .rdata(buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    c_d         = c_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done        = 1'b0;
    busy        = (state_q == RUN) || (state_q == FLUSH);

    // A drain and a new result in the same cycle leave the register full.
    if (out_fire) out_valid_d = 1'b0;
    if (new_res) begin
      out_data_d  = pool_max;
      out_valid_d = 1'b1;
    end
    if (in_fire && !c_q[0]) hold_d = x_relu;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = rows;
          cols_d  = cols;
          r_d     = '0;
          c_d     = '0;
          state_d = (rows == '0 || cols == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          if (last_col) begin
            c_d = '0;
            r_d = r_q + 7'd1;
          end else begin
            c_d = c_q + 7'd1;
          end
          if (last_in) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!out_valid_q || out_fire) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: pooled outputs checked against a plain array model.
module tb_relu_maxpool;
  localparam int DW = 16;
  localparam int MC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [6:0]    rows, cols;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy, done;

  always #5 clk = ~clk;

  relu_maxpool #(.DATA_W(DW), .MAX_COLS(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int vals[$];
  int mdl_q[$];
  int exp_q[$];
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  int rdy_mode = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int relu_i(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  // Expected pooled map straight from the definition: max of relu over each 2x2 tile.
  task automatic model(input int r, input int c);
    int m, v;
    mdl_q.delete();
    for (int i = 0; i < r / 2; i++)
      for (int j = 0; j < c / 2; j++) begin
        m = 0;
        for (int di = 0; di < 2; di++)
          for (int dj = 0; dj < 2; dj++) begin
            v = relu_i(vals[(2*i + di) * c + 2*j + dj]);
            if (v > m) m = v;
          end
        mdl_q.push_back(m);
      end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: got %0d want none", out_data);
        end else begin
          chk("out_data", int'(out_data), exp_q.pop_front());
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send(input int n, input int intr_at);
    int  t;
    logic ok;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(vals[k]);
      if (k == intr_at) begin
        start = 1'b1;
        rows  = 7'd2;
        cols  = 7'd2;
      end
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 100) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        t++;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL in_timeout: sample %0d got no in_ready want accept", k);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_map(input int r, input int c, input int rmode, input int intr_at);
    int d0, t;
    model(r, c);
    exp_q    = mdl_q;
    rdy_mode = rmode;
    d0       = done_cnt;
    @(posedge clk);
    #1;
    rows  = 7'(r);
    cols  = 7'(c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (r > 0 && c > 0) begin
      chk("in_ready_after_start", int'(in_ready), 1);
      chk("busy_after_start", int'(busy), 1);
    end
    send(r * c, intr_at);
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, d0 + 1);
    chk("all_outputs_delivered", exp_q.size(), 0);
    chk("busy_idle", int'(busy), 0);
    if (mdl_q.size() > 0 && r % 2 == 0 && c % 2 == 0)
      chk("done_latency", done_cyc, last_hs_cyc + 1);
    rdy_mode = 0;
  endtask

  task automatic load_ramp(input int n);
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; rows = '0; cols = '0; in_data = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    load_ramp(16);
    model(4, 4);
    chk("model_ramp_n", mdl_q.size(), 4);
    chk("model_ramp0", mdl_q[0], 5);
    chk("model_ramp1", mdl_q[1], 7);
    chk("model_ramp2", mdl_q[2], 13);
    chk("model_ramp3", mdl_q[3], 15);
    run_map(4, 4, 0, -1);

    vals = '{-3, -8, -1, -5};
    model(2, 2);
    chk("model_neg_a", mdl_q[0], 0);
    run_map(2, 2, 0, -1);

    vals = '{-4, 9, 2, -7};
    model(2, 2);
    chk("model_neg_b", mdl_q[0], 9);
    run_map(2, 2, 0, -1);

    vals.delete();
    for (int i = 1; i <= 15; i++) vals.push_back(i);
    model(5, 3);
    chk("model_odd_n", mdl_q.size(), 2);
    chk("model_odd0", mdl_q[0], 5);
    chk("model_odd1", mdl_q[1], 11);
    run_map(5, 3, 0, -1);

    load_ramp(16);
    run_map(4, 4, 1, -1);

    run_map(4, 4, 0, 5);

    run_map(0, 4, 0, -1);

    // Reset with a pooled result pending and the sink stalled.
    load_ramp(16);
    model(4, 4);
    exp_q    = mdl_q;
    rdy_mode = 2;
    d0       = done_cnt;
    @(posedge clk);
    #1 rows = 7'd4; cols = 7'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send(6, -1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);

    run_map(4, 4, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
